// File: rtl/compare_sequencer_if.sv
// Command/response bus of compare_sequencer.
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised, the payload beside it
// is held stable until that edge; ready may depend combinationally on valid,
// but valid never depends on ready.
interface compare_sequencer_if #(
  parameter int DATA_W = 6
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_mask;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_mask;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [3:0]        rsp_flags;

  // Requesters and result consumer.
  modport master (
    output req0_valid, req0_a, req0_b, req0_mask,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_mask,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_flags,
    output rsp_ready
  );

  // The sequencer.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_mask,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_mask,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_flags,
    input  rsp_ready
  );
endinterface

// File: rtl/compare_sequencer.sv
// compare_sequencer: shares one logic_operation comparator between two
// requesters. A granted command's masked comparisons run one per clock and
// their 1-bit results are packed into rsp_flags.
// Optional feature macro: CMP_SEQ_STATS_EN enables the per-requester
// saturating response counters; without it stat_cnt0/stat_cnt1 are tied to 0.

// Comparator shared by the sequencer. Only zLogic[0] carries the result.
module logic_operation (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic [1:0] comparison,
  output logic [5:0] zLogic
);
  logic result;

  // Select one of the four comparisons: eq, signed gt, signed lt, a is zero.
  always_comb begin
    result = 1'b0;
    case (comparison)
      2'b00:   result = (a == b);
      2'b01:   result = ($signed(a) > $signed(b));
      2'b10:   result = ($signed(a) < $signed(b));
      default: result = (a == 6'd0);
    endcase
  end

  assign zLogic = {5'd0, result};
endmodule

module compare_sequencer #(
  parameter int DATA_W  = 6,  // only 6 matches logic_operation
  parameter int FAIR_RR = 1   // 1: round-robin, 0: req0 has fixed priority
) (
  input  logic                clock,
  input  logic                reset,
  compare_sequencer_if.slave  bus,
  output logic                busy,
  output logic [7:0]          stat_cnt0,
  output logic [7:0]          stat_cnt1,
  output logic [1:0]          dbgState
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT             state;
  stateT             stateNext;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              rspFire;
  logic [3:0]        selMask;
  logic [1:0]        firstIndex;
  logic [1:0]        nextIndex;
  logic              nextFound;
  logic [1:0]        comparison;

  logic [DATA_W-1:0] aReg;
  logic [DATA_W-1:0] bReg;
  logic [3:0]        maskReg;
  logic              idReg;
  logic [3:0]        flags;
  logic [1:0]        idx;
  logic              lastGrant;

  logic [5:0]        zLogic;
  logic              unusedZBits;

  // Arbitration: only in IDLE; with both valid, round-robin picks the one not
  // served last, fixed priority always picks req0.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (FAIR_RR != 0) begin
          grant0 = lastGrant;
          grant1 = !lastGrant;
        end else begin
          grant0 = 1'b1;
        end
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign accept  = grant0 || grant1;
  assign selMask = grant1 ? bus.req1_mask : bus.req0_mask;
  assign rspFire = (state == RESP) && bus.rsp_ready;

  // Lowest set bit of the incoming mask is where RUN starts.
  always_comb begin
    firstIndex = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (selMask[i[1:0]]) firstIndex = i[1:0];
    end
  end

  // Next set mask bit above the current index; none found means last compare.
  always_comb begin
    nextFound = 1'b0;
    nextIndex = idx;
    for (int i = 3; i >= 0; i--) begin
      if (maskReg[i[1:0]] && (i[2:0] > {1'b0, idx})) begin
        nextFound = 1'b1;
        nextIndex = i[1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode and FSM-driven outputs.
  always_comb begin
    stateNext  = state;
    comparison = 2'b00;
    case (state)
      IDLE: begin
        if (accept) stateNext = (selMask != 4'd0) ? RUN : RESP;
      end
      RUN: begin
        comparison = idx;
        if (!nextFound) stateNext = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Command latch, per-compare flag capture and last-grant bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aReg      <= '0;
      bReg      <= '0;
      maskReg   <= 4'd0;
      idReg     <= 1'b0;
      flags     <= 4'd0;
      idx       <= 2'd0;
      lastGrant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            aReg    <= grant1 ? bus.req1_a : bus.req0_a;
            bReg    <= grant1 ? bus.req1_b : bus.req0_b;
            maskReg <= selMask;
            idReg   <= grant1;
            flags   <= 4'd0;
            idx     <= firstIndex;
          end
        end
        RUN: begin
          flags[idx] <= zLogic[0];
          idx        <= nextIndex;
        end
        RESP: begin
          if (bus.rsp_ready) lastGrant <= idReg;
        end
        default: ;
      endcase
    end
  end

  logic_operation u_logic_operation (
    .a          (aReg),
    .b          (bReg),
    .comparison (comparison),
    .zLogic     (zLogic)
  );

  // Upper comparator bits carry nothing for this block.
  assign unusedZBits = ^zLogic[5:1];

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = idReg;
  assign bus.rsp_flags  = flags;
  assign busy           = (state != IDLE);
  assign dbgState       = state;

`ifdef CMP_SEQ_STATS_EN
  logic [7:0] cnt0Reg;
  logic [7:0] cnt1Reg;

  // Saturating count of completed responses per requester.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt0Reg <= 8'd0;
      cnt1Reg <= 8'd0;
    end else if (rspFire) begin
      if (idReg) begin
        if (cnt1Reg != 8'hFF) cnt1Reg <= cnt1Reg + 8'd1;
      end else begin
        if (cnt0Reg != 8'hFF) cnt0Reg <= cnt0Reg + 8'd1;
      end
    end
  end

  assign stat_cnt0 = cnt0Reg;
  assign stat_cnt1 = cnt1Reg;
`else
  logic unusedFire;
  assign unusedFire = rspFire;
  assign stat_cnt0  = 8'd0;
  assign stat_cnt1  = 8'd0;
`endif
endmodule

// File: doc/compare_sequencer.md
# compare_sequencer

- Shares one `logic_operation` comparator between two requesters.
- Each request carries:
  - 6-bit two's-complement operands A and B.
  - A 4-bit mask selecting which of the four comparisons to run.
- The block arbitrates between requesters and runs the selected comparisons one per clock on an internal `logic_operation` instance. It packs the 1-bit results into a flag word and returns it on a response handshake.
- It sits between the operand sources and the ALU result path.

## Interface
Parameters:
- `DATA_W`, default 6: operand width. Only 6 is supported, to match `logic_operation`.
- `FAIR_RR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, req0 always wins.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a command.
- `req0_ready`  out  1  command accepted this cycle.
- `req0_a`  in  6  operand A.
- `req0_b`  in  6  operand B.
- `req0_mask`  in  4  bit i set = run comparison code i.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_mask`: same as the req0 ports, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  requester that issued the command.
- `rsp_flags`  out  4  bit i = result of comparison code i; 0 if not selected.
- `busy`  out  1  state is not IDLE.
- `stat_cnt0`, `stat_cnt1`  out  8  completed-response counts (see Configuration).

## Operation
- Comparison codes, as driven to `logic_operation.comparison`:
  - 00 = A==B
  - 01 = A>B (signed)
  - 10 = A<B (signed)
  - 11 = A==0
- The result is `zLogic[0]`; `zLogic[5:1]` is ignored.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - If any `reqN_valid` is high, grant one requester and assert its `reqN_ready` combinationally. The other ready stays 0.
  - On that edge (the acceptance edge E0), latch a, b, mask and id, and clear the flags.
  - Go to RUN if mask≠0, else to RESP.
- RUN:
  - A 2-bit index starts at the lowest set mask bit and drives `comparison`.
  - Each edge captures `zLogic[0]` into `flags[index]`, then advances the index to the next set bit.
  - After the highest set bit is captured, go to RESP.
  - RUN lasts exactly popcount(mask) cycles.
- RESP:
  - `rsp_valid` is 1. `rsp_id` and `rsp_flags` hold stable until `rsp_valid && rsp_ready` at an edge.
  - On the handshake, go to IDLE and record `rsp_id` as the last grant.
- Arbitration:
  - `FAIR_RR=1`: with both valid, grant the requester that was not last granted. The last grant resets to 1, so req0 wins first.
  - `FAIR_RR=0`: req0 wins whenever valid.
- No command is accepted in RUN or RESP; both readies are 0 there.
- `comparison` drives 00 outside RUN.
- The operand latches feed `logic_operation.a` and `.b`. The requester inputs need not stay stable after E0.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_flags`=0, `busy`=0
  - `req0_ready`=`req1_ready`=0
  - state = IDLE, last grant = 1, stat counters = 0
- Latency: with N = popcount(mask), `rsp_valid` rises after edge E0+N. For N=0 it rises directly after E0.
- Throughput: at least one IDLE cycle follows each response handshake, so the minimum command period is N+2 cycles.
- No combinational path from `rsp_ready` or any input to `rsp_valid`. The only combinational input-to-output paths are `reqN_valid` → `reqN_ready`.
- Reset asserted mid-RUN or mid-RESP:
  - The in-flight command is discarded and no response is produced.
  - All outputs return to their reset values immediately; the reset is asynchronous.

## Configuration
- `CMP_SEQ_STATS_EN` defined:
  - `stat_cnt0` and `stat_cnt1` count completed response handshakes per `rsp_id`.
  - Counters saturate at 255 and clear on reset.
- Undefined: the counter logic is absent and both ports are tied to 0.

## Test plan
- **Full mask, A>B:** req0 A=000111 (+7), B=111000 (−8), mask 1111 → `rsp_flags`=0010, `rsp_id`=0, `rsp_valid` rises after E0+4.
- **A zero:** req1 A=000000, B=110001 (−15), mask 1111 → `rsp_flags`=1010, `rsp_id`=1.
- **Partial mask:**
  - A=B=000101, mask 0101 → flags 0001, latency 2.
  - Mask 0000 → flags 0000, `rsp_valid` right after E0.
- **Simultaneous requests:** both valid; req0 −20/+24 mask 0100, req1 −8/−8 mask 0001.
  - req0 is served first (flags 0100), then req1 (flags 0001).
  - With both held valid, grants alternate 0,1,0,1.
  - With `FAIR_RR=0`, req0 wins every time.
- **Backpressure and reset:**
  - `rsp_ready` held low for 5 cycles → `rsp_valid`, `rsp_flags` and `rsp_id` stay stable, and both readies stay 0.
  - `reset` pulsed during RUN → outputs return to reset values at once, no response, next command served normally.
- **Stats (`CMP_SEQ_STATS_EN`):** 3 req0 and 2 req1 responses → `stat_cnt0`=3, `stat_cnt1`=2. 300 req0 responses → `stat_cnt0`=255.
